// File: rtl/sram_ctrl_pkg.sv
// rtl/sram_ctrl_pkg.sv - shared FSM encodings and default geometry for the SRAM initiator
package sram_ctrl_pkg;

  localparam int ADDR_W_DEF      = 10;
  localparam int DATA_W_DEF      = 8;
  localparam int WAIT_CYCLES_DEF = 3;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SETUP  = 3'd1;
  localparam logic [2:0] ST_ACCESS = 3'd2;
  localparam logic [2:0] ST_DONE   = 3'd3;
  localparam logic [2:0] ST_TURN   = 3'd4;

  // ACCESS down-counter preload: expires after wait_cycles ACCESS cycles
  function automatic logic [3:0] access_load(input int wait_cycles);
    return 4'(wait_cycles - 1);
  endfunction

endpackage

// File: rtl/sram_ctrl_iobuf.sv
// rtl/sram_ctrl_iobuf.sv - tri-state buffer isolating the shared SRAM data bus from the FSM
module sram_ctrl_iobuf #(
  parameter int DATA_W = 8
) (
  input  logic              oe,
  input  logic [DATA_W-1:0] dout,
  output logic [DATA_W-1:0] din,
  inout  wire  [DATA_W-1:0] io
);

  assign io  = oe ? dout : {DATA_W{1'bz}};
  assign din = io;

endmodule

// File: rtl/sram_ctrl.sv
// rtl/sram_ctrl.sv - valid/ready host requests to timed async SRAM cycles; optional SRAM_CTRL_TURNAROUND_EN adds a post-write TURN cycle
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int WAIT_CYCLES = WAIT_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [ADDR_W-1:0] sram_addr,
  output logic              sram_cs,
  output logic              sram_rws,
  inout  wire  [DATA_W-1:0] sram_io
);

  logic [2:0]        r_state;
  logic [3:0]        r_cnt;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;

  logic              w_cycle;
  logic              w_oe;
  logic [DATA_W-1:0] w_din;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_we    <= req_we;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_state <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          r_cnt   <= access_load(WAIT_CYCLES);
          r_state <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (r_cnt == 4'd0) begin
            if (!r_we) r_rdata <= w_din;
            r_state <= ST_DONE;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        ST_DONE: begin
`ifdef SRAM_CTRL_TURNAROUND_EN
          r_state <= r_we ? ST_TURN : ST_IDLE;
`else
          r_state <= ST_IDLE;
`endif
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // cs/rws/bus are decoded from state so an async reset releases the SRAM immediately
  assign w_cycle   = (r_state == ST_SETUP) || (r_state == ST_ACCESS);
  assign w_oe      = (r_state == ST_ACCESS) && r_we;
  assign req_ready = (r_state == ST_IDLE);
  assign rsp_valid = (r_state == ST_DONE);
  assign rsp_rdata = r_rdata;
  assign sram_addr = r_addr;
  assign sram_cs   = w_cycle;
  assign sram_rws  = w_cycle && r_we;

  sram_ctrl_iobuf #(.DATA_W(DATA_W)) u_iobuf (
    .oe   (w_oe),
    .dout (r_wdata),
    .din  (w_din),
    .io   (sram_io)
  );

endmodule
